// File: rtl/rab_lookup_ctrl_pkg.sv
// Shared types for the RAB lookup controller: FSM state encoding and the
// registered lookup-result record.
package rab_lookup_ctrl_pkg;

  // Widest physical address the result record can carry.
  localparam int RAB_PHYS_AW = 40;

  // Channel indices used by the two-way arbiter (bit 0 = write, bit 1 = read).
  localparam int RAB_CH_WR = 0;
  localparam int RAB_CH_RD = 1;

  typedef enum logic [1:0] {
    RAB_IDLE   = 2'd0,
    RAB_LOOKUP = 2'd1,
    RAB_RESP   = 2'd2
  } rab_state_e;

  // Outcome of one lookup, captured during LOOKUP and held through RESP.
  typedef struct packed {
    logic                   miss;
    logic                   multi;
    logic                   prot;
    logic                   coherent;
    logic [RAB_PHYS_AW-1:0] addr;
  } rab_result_t;

endpackage

// File: rtl/rab_lookup_ctrl_if.sv
// Bundle of the request, slice-array and result channels of the lookup
// controller. Handshake rule on every valid/ready pair: a transfer happens in
// the cycle where valid and ready are both 1 at the rising clock edge; the
// payload travels with valid and is held by the source until that edge.
interface rab_lookup_ctrl_if #(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 8
);
  // write request channel
  logic                       wr_valid_i;
  logic                       wr_ready_o;
  logic [ADDR_WIDTH_VIRT-1:0] wr_addr_i;
  logic [7:0]                 wr_len_i;
  logic [2:0]                 wr_size_i;
  logic [ID_WIDTH-1:0]        wr_id_i;
  // read request channel
  logic                       rd_valid_i;
  logic                       rd_ready_o;
  logic [ADDR_WIDTH_VIRT-1:0] rd_addr_i;
  logic [7:0]                 rd_len_i;
  logic [2:0]                 rd_size_i;
  logic [ID_WIDTH-1:0]        rd_id_i;
  // lookup request towards the slice array
  logic                       int_rw_o;
  logic [ADDR_WIDTH_VIRT-1:0] int_addr_min_o;
  logic [ADDR_WIDTH_VIRT-1:0] int_addr_max_o;
  // lookup result from the slice array
  logic [N_SLICES-1:0]        hit_i;
  logic [N_SLICES-1:0]        prot_i;
  logic                       multiple_hit_i;
  logic                       cache_coherent_i;
  logic [ADDR_WIDTH_PHYS-1:0] out_addr_i;
  // result channel
  logic                       res_valid_o;
  logic                       res_ready_i;
  logic                       res_rw_o;
  logic [ID_WIDTH-1:0]        res_id_o;
  logic [ADDR_WIDTH_PHYS-1:0] res_addr_o;
  logic                       res_miss_o;
  logic                       res_prot_o;
  logic                       res_multi_o;
  logic                       res_coherent_o;

  // Environment side: issues requests, answers lookups, consumes results.
  modport master (
    output wr_valid_i, wr_addr_i, wr_len_i, wr_size_i, wr_id_i,
    input  wr_ready_o,
    output rd_valid_i, rd_addr_i, rd_len_i, rd_size_i, rd_id_i,
    input  rd_ready_o,
    input  int_rw_o, int_addr_min_o, int_addr_max_o,
    output hit_i, prot_i, multiple_hit_i, cache_coherent_i, out_addr_i,
    input  res_valid_o, res_rw_o, res_id_o, res_addr_o,
    input  res_miss_o, res_prot_o, res_multi_o, res_coherent_o,
    output res_ready_i
  );

  // Controller side.
  modport slave (
    input  wr_valid_i, wr_addr_i, wr_len_i, wr_size_i, wr_id_i,
    output wr_ready_o,
    input  rd_valid_i, rd_addr_i, rd_len_i, rd_size_i, rd_id_i,
    output rd_ready_o,
    output int_rw_o, int_addr_min_o, int_addr_max_o,
    input  hit_i, prot_i, multiple_hit_i, cache_coherent_i, out_addr_i,
    output res_valid_o, res_rw_o, res_id_o, res_addr_o,
    output res_miss_o, res_prot_o, res_multi_o, res_coherent_o,
    input  res_ready_i
  );

endinterface

// File: rtl/rab_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the write channel, bit 1 the
// read channel. A grant is also the handshake (ready = grant, and a grant is
// only given to a valid requester), so the pointer moves on every grant.
module rab_rr_arb2
  import rab_lookup_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when the read channel was granted last, so write has priority next.
  logic last_rd_q;

  // Lone requester wins; on contention the channel not granted last wins.
  always_comb begin
    gnt            = 2'b00;
    gnt[RAB_CH_WR] = en && req[RAB_CH_WR] && (!req[RAB_CH_RD] || last_rd_q);
    gnt[RAB_CH_RD] = en && req[RAB_CH_RD] && (!req[RAB_CH_WR] || !last_rd_q);
  end

  // Remember who was granted; reset leaves write as the first winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else if (gnt[RAB_CH_WR]) begin
      last_rd_q <= 1'b0;
    end else if (gnt[RAB_CH_RD]) begin
      last_rd_q <= 1'b1;
    end
  end

endmodule

// File: rtl/rab_lookup_ctrl.sv
// RAB lookup controller: arbitrates read/write requests, presents the address
// range of the accepted burst to the slice array, captures the lookup outcome
// and hands it out on the result channel. One request in flight at a time:
// IDLE (accept) -> LOOKUP (sample slice array) -> RESP (wait for res_ready_i).
module rab_lookup_ctrl
  import rab_lookup_ctrl_pkg::*;
#(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 8
)(
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  rab_lookup_ctrl_if.slave bus,
  output rab_state_e       dbg_state
);

  localparam int AW = ADDR_WIDTH_VIRT;

  rab_state_e          state_q, state_d;
  logic [1:0]          req, gnt;
  logic                arb_en;

  logic                sel_rd;
  logic [AW-1:0]       sel_addr;
  logic [7:0]          sel_len;
  logic [2:0]          sel_size;
  logic [ID_WIDTH-1:0] sel_id;
  logic [AW:0]         span, sum;
  logic [AW-1:0]       addr_max;

  logic                rw_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [AW-1:0]       amin_q, amax_q;

  logic [N_SLICES-1:0] hit, prot;
  rab_result_t         res_q, res_d;

  assign req    = {bus.rd_valid_i, bus.wr_valid_i};
  // Ready is withheld outside IDLE and while reset is asserted.
  assign arb_en = Rst_RBI && (state_q == RAB_IDLE);

  rab_rr_arb2 u_arb (
    .clk   (Clk_CI),
    .rst_n (Rst_RBI),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.wr_ready_o = gnt[RAB_CH_WR];
  assign bus.rd_ready_o = gnt[RAB_CH_RD];

  // Select the granted channel and compute the last byte of its burst; the
  // extra top bit catches a burst running past the end of the address space.
  always_comb begin
    sel_rd   = gnt[RAB_CH_RD];
    sel_addr = sel_rd ? bus.rd_addr_i : bus.wr_addr_i;
    sel_len  = sel_rd ? bus.rd_len_i  : bus.wr_len_i;
    sel_size = sel_rd ? bus.rd_size_i : bus.wr_size_i;
    sel_id   = sel_rd ? bus.rd_id_i   : bus.wr_id_i;
    span     = ((AW+1)'(sel_len) + (AW+1)'(1)) << sel_size;
    sum      = {1'b0, sel_addr} + span - (AW+1)'(1);
    addr_max = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
  end

  // Capture the accepted request; it keeps driving the slice array afterwards.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      rw_q   <= 1'b0;
      id_q   <= '0;
      amin_q <= '0;
      amax_q <= '0;
    end else if (|gnt) begin
      rw_q   <= gnt[RAB_CH_WR];
      id_q   <= sel_id;
      amin_q <= sel_addr;
      amax_q <= addr_max;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= RAB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RAB_IDLE:   if (|gnt) state_d = RAB_LOOKUP;
      RAB_LOOKUP: state_d = RAB_RESP;
      RAB_RESP:   if (bus.res_ready_i) state_d = RAB_IDLE;
      default:    state_d = RAB_IDLE;
    endcase
  end

  assign hit  = bus.hit_i;
  assign prot = bus.prot_i;

  // Interpret the slice-array answer; a miss or an ambiguous hit yields no
  // usable translation, so address and coherency are forced to 0.
  always_comb begin
    res_d          = '0;
    res_d.miss     = (hit == '0);
    res_d.multi    = bus.multiple_hit_i;
    res_d.prot     = |(hit & prot);
    if (!res_d.miss && !res_d.multi) begin
      res_d.addr     = RAB_PHYS_AW'(bus.out_addr_i);
      res_d.coherent = bus.cache_coherent_i;
    end
  end

  // Result register: loaded once in LOOKUP, then frozen through RESP.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      res_q <= '0;
    end else if (state_q == RAB_LOOKUP) begin
      res_q <= res_d;
    end
  end

  assign bus.int_rw_o       = rw_q;
  assign bus.int_addr_min_o = amin_q;
  assign bus.int_addr_max_o = amax_q;

  assign bus.res_valid_o    = (state_q == RAB_RESP);
  assign bus.res_rw_o       = rw_q;
  assign bus.res_id_o       = id_q;
  assign bus.res_addr_o     = ADDR_WIDTH_PHYS'(res_q.addr);
  assign bus.res_miss_o     = res_q.miss;
  assign bus.res_prot_o     = res_q.prot;
  assign bus.res_multi_o    = res_q.multi;
  assign bus.res_coherent_o = res_q.coherent;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rab_lookup_ctrl.sv
// Bench for rab_lookup_ctrl: directed vector table, hand-written multi-cycle
// sequences (arbitration order, back-pressure hold, reset in LOOKUP), then
// random traffic against a transaction-level reference model.
module tb_rab_lookup_ctrl;
  import rab_lookup_ctrl_pkg::*;

  localparam int NS = 16;
  localparam int AV = 32;
  localparam int AP = 40;
  localparam int IW = 8;
  localparam int RW = 1 + IW + AP + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rab_lookup_ctrl_if #(.N_SLICES(NS), .ADDR_WIDTH_VIRT(AV), .ADDR_WIDTH_PHYS(AP), .ID_WIDTH(IW)) bus ();
  rab_state_e dbg_state;

  rab_lookup_ctrl #(.N_SLICES(NS), .ADDR_WIDTH_VIRT(AV), .ADDR_WIDTH_PHYS(AP), .ID_WIDTH(IW)) dut (
    .Clk_CI    (clk),
    .Rst_RBI   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_wr(input logic v, input logic [AV-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [IW-1:0] id);
    bus.wr_valid_i = v; bus.wr_addr_i = a; bus.wr_len_i = l; bus.wr_size_i = s; bus.wr_id_i = id;
  endtask

  task automatic drive_rd(input logic v, input logic [AV-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [IW-1:0] id);
    bus.rd_valid_i = v; bus.rd_addr_i = a; bus.rd_len_i = l; bus.rd_size_i = s; bus.rd_id_i = id;
  endtask

  task automatic drive_lookup(input logic [NS-1:0] h, input logic [NS-1:0] p, input logic m,
                              input logic c, input logic [AP-1:0] o);
    bus.hit_i = h; bus.prot_i = p; bus.multiple_hit_i = m; bus.cache_coherent_i = c; bus.out_addr_i = o;
  endtask

  task automatic scramble_lookup();
    drive_lookup(NS'($urandom), NS'($urandom), 1'($urandom), 1'($urandom), {8'($urandom), 32'($urandom)});
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Holds reset two edges with both channels requesting, checks the reset
  // state, then releases. Returns just after a rising edge, DUT in IDLE.
  task automatic do_reset(input string tag);
    next_cycle();
    rst_n = 1'b0;
    bus.wr_valid_i = 1'b1; bus.rd_valid_i = 1'b1; bus.res_ready_i = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check({tag, "_wr_ready"}, 64'(bus.wr_ready_o), 64'd0);
    check({tag, "_rd_ready"}, 64'(bus.rd_ready_o), 64'd0);
    check({tag, "_res_valid"}, 64'(bus.res_valid_o), 64'd0);
    check({tag, "_int_rw"}, 64'(bus.int_rw_o), 64'd0);
    check({tag, "_int_min"}, 64'(bus.int_addr_min_o), 64'd0);
    check({tag, "_int_max"}, 64'(bus.int_addr_max_o), 64'd0);
    check({tag, "_res_fields"}, {bus.res_addr_o, bus.res_id_o, bus.res_miss_o, bus.res_multi_o,
                                 bus.res_prot_o, bus.res_coherent_o}, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(RAB_IDLE));
    next_cycle();
    rst_n = 1'b1;
    bus.wr_valid_i = 1'b0; bus.rd_valid_i = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rw;
    logic [AV-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [IW-1:0] id;
    logic [NS-1:0] hit;
    logic [NS-1:0] prot;
    logic          multi;
    logic          coh;
    logic [AP-1:0] out_addr;
    logic [AV-1:0] exp_amax;
    logic [AP-1:0] exp_raddr;
    logic          exp_miss;
    logic          exp_multi;
    logic          exp_prot;
    logic          exp_coh;
  } vec_t;

  vec_t vecs[6];

  // One request through IDLE -> LOOKUP -> RESP with one stall cycle in RESP.
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    bus.res_ready_i = 1'b0;
    if (v.rw) begin
      drive_wr(1'b1, v.addr, v.len, v.size, v.id); bus.rd_valid_i = 1'b0;
    end else begin
      drive_rd(1'b1, v.addr, v.len, v.size, v.id); bus.wr_valid_i = 1'b0;
    end
    @(negedge clk);
    check({p, "_ready"}, 64'(v.rw ? bus.wr_ready_o : bus.rd_ready_o), 64'd1);
    check({p, "_other_ready"}, 64'(v.rw ? bus.rd_ready_o : bus.wr_ready_o), 64'd0);
    next_cycle();
    bus.wr_valid_i = 1'b0; bus.rd_valid_i = 1'b0;
    drive_lookup(v.hit, v.prot, v.multi, v.coh, v.out_addr);
    @(negedge clk);
    check({p, "_int_rw"}, 64'(bus.int_rw_o), 64'(v.rw));
    check({p, "_int_min"}, 64'(bus.int_addr_min_o), 64'(v.addr));
    check({p, "_int_max"}, 64'(bus.int_addr_max_o), 64'(v.exp_amax));
    check({p, "_valid_lat1"}, 64'(bus.res_valid_o), 64'd0);
    next_cycle();
    scramble_lookup();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check({p, $sformatf("_res_valid%0d", k)}, 64'(bus.res_valid_o), 64'd1);
      check({p, "_res_rw"}, 64'(bus.res_rw_o), 64'(v.rw));
      check({p, "_res_id"}, 64'(bus.res_id_o), 64'(v.id));
      check({p, "_res_addr"}, 64'(bus.res_addr_o), 64'(v.exp_raddr));
      check({p, "_res_flags"}, {60'd0, bus.res_miss_o, bus.res_multi_o, bus.res_prot_o, bus.res_coherent_o},
            {60'd0, v.exp_miss, v.exp_multi, v.exp_prot, v.exp_coh});
      next_cycle();
      bus.res_ready_i = (k == 0);
    end
    @(negedge clk);
    check({p, "_res_done"}, 64'(bus.res_valid_o), 64'd0);
    next_cycle();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AV-1:0] ref_amax(input logic [AV-1:0] a, input logic [7:0] l, input logic [2:0] s);
    longint unsigned bytes, last;
    bytes = (64'(l) + 64'd1) * (64'd1 << s);
    last  = 64'(a) + bytes - 64'd1;
    if (last > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return last[AV-1:0];
  endfunction

  function automatic logic [RW-1:0] pack_res(input logic rw, input logic [IW-1:0] id, input logic [AP-1:0] a,
                                             input logic mi, input logic mu, input logic pr, input logic co);
    return {rw, id, a, mi, mu, pr, co};
  endfunction

  logic [RW-1:0] exp_q[$];

  initial begin
    int ord[$];
    int at[$];
    int grants, both, cyc;
    int pending;
    logic last_w, m_rw;
    logic [IW-1:0] m_id;
    logic [AV-1:0] m_amin, m_amax;
    int win;

    vecs[0] = '{1'b1, 32'h1000_0000, 8'd3, 3'd2, 8'h11, 16'h0020, 16'h0000, 1'b0, 1'b1, 40'h80_2000_0000,
                32'h1000_000F, 40'h80_2000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h2000_0000, 8'd0, 3'd0, 8'h22, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 40'h12_3456_7890,
                32'h2000_0000, 40'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h3000_0100, 8'd1, 3'd1, 8'h33, 16'h0003, 16'h0002, 1'b1, 1'b1, 40'h00_0000_0055,
                32'h3000_0103, 40'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFF_FFF0, 8'd7, 3'd3, 8'h44, 16'h8000, 16'h8000, 1'b0, 1'b0, 40'hAB_CDEF_0123,
                32'hFFFF_FFFF, 40'hAB_CDEF_0123, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FF00, 8'd127, 3'd0, 8'h55, 16'h0100, 16'h0000, 1'b0, 1'b1, 40'h01_0000_0000,
                32'hFFFF_FF7F, 40'h01_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 8'd255, 3'd7, 8'hFE, 16'h4000, 16'h4001, 1'b0, 1'b1, 40'hFF_FFFF_FFFF,
                32'h0000_7FFF, 40'hFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};

    drive_wr(1'b0, '0, '0, '0, '0);
    drive_rd(1'b0, '0, '0, '0, '0);
    drive_lookup('0, '0, 1'b0, 1'b0, '0);
    bus.res_ready_i = 1'b0;

    do_reset("rst0");
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Both channels requesting continuously: W,R,W,R, three cycles apart.
    do_reset("rst1");
    drive_wr(1'b1, 32'h0000_1000, 8'd0, 3'd2, 8'h01);
    drive_rd(1'b1, 32'h0000_2000, 8'd1, 3'd2, 8'h02);
    drive_lookup(16'h0001, 16'h0000, 1'b0, 1'b1, 40'h1_0000);
    bus.res_ready_i = 1'b1;
    grants = 0; both = 0; cyc = 0;
    while (grants < 4 && cyc < 40) begin
      @(negedge clk);
      if (bus.wr_ready_o && bus.rd_ready_o) both++;
      if (bus.wr_ready_o || bus.rd_ready_o) begin
        ord.push_back(bus.wr_ready_o ? 0 : 1);
        at.push_back(cyc);
        grants++;
      end
      next_cycle();
      cyc++;
    end
    bus.wr_valid_i = 1'b0; bus.rd_valid_i = 1'b0;
    check("rr_grants", 64'(grants), 64'd4);
    check("rr_both_ready", 64'(both), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_order%0d", i), 64'(i < ord.size() ? ord[i] : 9), 64'(i % 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), 64'(i < at.size() ? at[i] - at[i-1] : 0), 64'd3);
    end
    next_cycle(); next_cycle(); next_cycle();
    bus.res_ready_i = 1'b0;

    // Back-pressure: result held 10 cycles, no request accepted meanwhile.
    drive_wr(1'b1, 32'h4000_0000, 8'd0, 3'd0, 8'h5A);
    @(negedge clk);
    check("hold_accept", 64'(bus.wr_ready_o), 64'd1);
    next_cycle();
    drive_lookup(16'h0010, 16'h0000, 1'b0, 1'b1, 40'h77_0000_1000);
    bus.rd_valid_i = 1'b1;
    @(negedge clk);
    check("hold_lookup_ready", 64'({bus.wr_ready_o, bus.rd_ready_o}), 64'd0);
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      scramble_lookup();
      @(negedge clk);
      check("hold_valid", 64'(bus.res_valid_o), 64'd1);
      check("hold_addr", 64'(bus.res_addr_o), 64'h77_0000_1000);
      check("hold_id_rw", 64'({bus.res_id_o, bus.res_rw_o}), 64'({8'h5A, 1'b1}));
      check("hold_flags", 64'({bus.res_miss_o, bus.res_multi_o, bus.res_prot_o, bus.res_coherent_o}), 64'b0001);
      check("hold_ready", 64'({bus.wr_ready_o, bus.rd_ready_o}), 64'd0);
      next_cycle();
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 64'({bus.wr_ready_o, bus.rd_ready_o}), 64'd0);
    next_cycle();
    bus.wr_valid_i = 1'b0; bus.rd_valid_i = 1'b0; bus.res_ready_i = 1'b0;
    @(negedge clk);
    check("hold_done", 64'(bus.res_valid_o), 64'd0);
    next_cycle();

    // Reset while in LOOKUP: request dropped, arbitration back to write-first.
    drive_wr(1'b1, 32'h5000_0000, 8'd3, 3'd0, 8'h66);
    @(negedge clk);
    check("rstlk_accept", 64'(bus.wr_ready_o), 64'd1);
    next_cycle();
    rst_n = 1'b0;
    bus.rd_valid_i = 1'b1;
    drive_lookup(16'h0001, 16'h0000, 1'b0, 1'b1, 40'h12_0000);
    @(negedge clk);
    check("rstlk_in_lookup", 64'(dbg_state), 64'(RAB_LOOKUP));
    next_cycle();
    @(negedge clk);
    check("rstlk_state", 64'(dbg_state), 64'(RAB_IDLE));
    check("rstlk_res_valid", 64'(bus.res_valid_o), 64'd0);
    check("rstlk_int_max", 64'(bus.int_addr_max_o), 64'd0);
    check("rstlk_ready_rst", 64'({bus.wr_ready_o, bus.rd_ready_o}), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstlk_res_valid_after", 64'(bus.res_valid_o), 64'd0);
    check("rstlk_next_grant", 64'({bus.wr_ready_o, bus.rd_ready_o}), 64'b10);
    next_cycle();
    bus.wr_valid_i = 1'b0; bus.rd_valid_i = 1'b0; bus.res_ready_i = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    bus.res_ready_i = 1'b0;

    // Random traffic against the reference model.
    do_reset("rst2");
    pending = 0; last_w = 1'b0; m_rw = 1'b0; m_id = '0; m_amin = '0; m_amax = '0;
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      drive_wr(1'($urandom_range(0, 1)), AV'($urandom), 8'($urandom), 3'($urandom), IW'($urandom));
      drive_rd(1'($urandom_range(0, 1)), AV'($urandom), 8'($urandom), 3'($urandom), IW'($urandom));
      case ($urandom_range(0, 3))
        0:       bus.hit_i = '0;
        1:       bus.hit_i = NS'(1) << $urandom_range(0, NS - 1);
        default: bus.hit_i = NS'($urandom);
      endcase
      bus.prot_i = NS'($urandom);
      bus.multiple_hit_i = ($urandom_range(0, 5) == 0);
      bus.cache_coherent_i = 1'($urandom);
      bus.out_addr_i = {8'($urandom), 32'($urandom)};
      bus.res_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      // Who should be accepted this cycle (0 none, 1 write, 2 read).
      win = 0;
      if (pending == 0) begin
        if (bus.wr_valid_i && bus.rd_valid_i) win = last_w ? 2 : 1;
        else if (bus.wr_valid_i) win = 1;
        else if (bus.rd_valid_i) win = 2;
      end
      check("rnd_wr_ready", 64'(bus.wr_ready_o), 64'(win == 1));
      check("rnd_rd_ready", 64'(bus.rd_ready_o), 64'(win == 2));
      check("rnd_res_valid", 64'(bus.res_valid_o), 64'(pending == 2));
      check("rnd_int", {bus.int_rw_o, bus.int_addr_min_o, bus.int_addr_max_o}, {m_rw, m_amin, m_amax});
      if (pending == 2 && exp_q.size() > 0)
        check("rnd_result", 64'(pack_res(bus.res_rw_o, bus.res_id_o, bus.res_addr_o, bus.res_miss_o,
                                         bus.res_multi_o, bus.res_prot_o, bus.res_coherent_o)), 64'(exp_q[0]));
      if (pending == 0 && win != 0) begin
        m_rw   = (win == 1);
        m_id   = m_rw ? bus.wr_id_i : bus.rd_id_i;
        m_amin = m_rw ? bus.wr_addr_i : bus.rd_addr_i;
        m_amax = m_rw ? ref_amax(bus.wr_addr_i, bus.wr_len_i, bus.wr_size_i)
                      : ref_amax(bus.rd_addr_i, bus.rd_len_i, bus.rd_size_i);
        last_w = m_rw;
        pending = 1;
      end else if (pending == 1) begin
        logic mi, mu, pr;
        mi = (bus.hit_i == '0);
        mu = bus.multiple_hit_i;
        pr = ((bus.hit_i & bus.prot_i) != '0);
        if (mi || mu) exp_q.push_back(pack_res(m_rw, m_id, '0, mi, mu, pr, 1'b0));
        else exp_q.push_back(pack_res(m_rw, m_id, bus.out_addr_i, mi, mu, pr, bus.cache_coherent_i));
        pending = 2;
      end else if (pending == 2 && bus.res_ready_i) begin
        void'(exp_q.pop_front());
        pending = 0;
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rab_lookup_ctrl.md
RAB_LOOKUP_CTRL -- requirements
Module: rab_lookup_ctrl

Interface
REQ-001 Parameter N_SLICES, default 16, number of translation slices in the downstream lookup stage.
REQ-002 Parameter ADDR_WIDTH_VIRT, default 32, virtual address width.
REQ-003 Parameter ADDR_WIDTH_PHYS, default 40, physical address width.
REQ-004 Parameter ID_WIDTH, default 8, transaction ID width.
REQ-005 Port Clk_CI  in  1  clock; the block SHALL use one clock and a synchronous active-low reset.
REQ-006 Port Rst_RBI  in  1  synchronous active-low reset.
REQ-007 Ports wr_valid_i in 1, wr_ready_o out 1, wr_addr_i in ADDR_WIDTH_VIRT, wr_len_i in 8, wr_size_i in 3, wr_id_i in ID_WIDTH: write request channel.
REQ-008 Ports rd_valid_i, rd_ready_o, rd_addr_i, rd_len_i, rd_size_i, rd_id_i: read request channel, same widths as the write channel.
REQ-009 Ports int_rw_o out 1 (1=write), int_addr_min_o out ADDR_WIDTH_VIRT, int_addr_max_o out ADDR_WIDTH_VIRT: lookup request to the slice array.
REQ-010 Ports hit_i in N_SLICES, prot_i in N_SLICES, multiple_hit_i in 1, cache_coherent_i in 1, out_addr_i in ADDR_WIDTH_PHYS: lookup result from the slice array.
REQ-011 Ports res_valid_o out 1, res_ready_i in 1, res_rw_o out 1, res_id_o out ID_WIDTH, res_addr_o out ADDR_WIDTH_PHYS, res_miss_o, res_prot_o, res_multi_o, res_coherent_o out 1 each: lookup result channel.

Function
REQ-012 The FSM SHALL have states IDLE, LOOKUP, RESP, with transitions IDLE->LOOKUP on a grant, LOOKUP->RESP unconditionally, RESP->IDLE when res_ready_i=1, and otherwise holding state.
REQ-013 In IDLE, arbitration SHALL be round-robin: a lone valid channel wins; if both are valid, the channel not granted last wins; after reset, write wins first.
REQ-014 wr_ready_o/rd_ready_o SHALL be 1 only in IDLE for the granted channel, combinationally; the handshake occurs when valid and ready are both 1.
REQ-015 On handshake, the block SHALL register rw, id, addr_min=addr, and addr_max=addr+((len+1)<<size)-1, computed 1 bit wider than ADDR_WIDTH_VIRT.
REQ-016 If that sum exceeds the address space (carry out), addr_max SHALL saturate to all-ones.
REQ-017 int_rw_o/int_addr_min_o/int_addr_max_o SHALL drive the registered request in all states, and SHALL be 0 after reset until the first grant.
REQ-018 In LOOKUP, the block SHALL sample the lookup inputs into result registers: miss = (hit_i==0); multi = multiple_hit_i; prot = |(hit_i & prot_i).
REQ-019 In LOOKUP, if miss or multi is set, the block SHALL register addr=0 and coherent=0; otherwise it SHALL register addr=out_addr_i and coherent=cache_coherent_i.
REQ-020 res_valid_o SHALL be 1 exactly in RESP; all res_* outputs SHALL be stable while res_valid_o=1 and res_ready_i=0.
REQ-021 Latency from request handshake to res_valid_o SHALL be 2 cycles, and peak throughput SHALL be one request per 3 cycles.
REQ-022 No new request SHALL be accepted in LOOKUP or RESP, including the cycle in which res_ready_i is sampled 1.

Reset
REQ-023 With Rst_RBI=0 at a clock edge, the block SHALL enter IDLE, clear all registered outputs and the result fields to 0, and set the round-robin pointer to write-first.
REQ-024 Reset asserted in LOOKUP or RESP SHALL discard the pending request with no result emitted, and ready SHALL be 0 during reset.

Structure
REQ-025 The FSM state enum and a lookup-result struct (miss, multi, prot, coherent, addr) SHALL reside in the shared rab package.
REQ-026 Arbitration SHALL be a sub-module rab_rr_arb2 (two requesters, round-robin, sync active-low reset).

Verification
REQ-027 Write: addr 0x1000_0000, len 3, size 2, single hit slice 5, out_addr 0x80_2000_0000 -> int_addr_max 0x1000_000F; res_addr 0x80_2000_0000, miss/multi 0, res_valid 2 cycles after handshake.
REQ-028 Read and write valid together for 4 requests, res_ready_i tied 1 -> grant order W,R,W,R, each accepted 3 cycles apart.
REQ-029 hit_i=0 -> res_miss 1, res_addr 0, res_coherent 0; hit_i=0x0003 with multiple_hit_i=1 -> res_multi 1, res_addr 0.
REQ-030 addr 0xFFFF_FFF0, len 7, size 3 -> int_addr_max saturates to 0xFFFF_FFFF.
REQ-031 res_ready_i held 0 for 10 cycles in RESP -> outputs stable, both ready outputs 0; reset asserted in LOOKUP -> IDLE, res_valid 0, next grant goes to write.
